// File: rtl/ps_ureg_file.sv
// ps_ureg_file: universal-register file holding the PC stack (PCSTK/PCSTKP),
// the loop counter (LCNTR), MODE1 and the sticky stack-error register (STKY).
// Reads are combinational from ps_rd_add. Writes land on the clock edge and
// are never bypassed to the read port.
// Optional feature: define PS_UREG_STKY_EN to build the STKY register and the
// ps_stky_err flag. Without it, 0x08 reads 0 and ps_stky_err is tied low.
module ps_ureg_file #(
  parameter int PS_DATA_W    = 16,
  parameter int PS_STK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps_wrt_en,
  input  logic [4:0]           ps_wrt_add,
  input  logic [PS_DATA_W-1:0] ps_wrt_data,
  input  logic [4:0]           ps_rd_add,
  input  logic                 ps_popstck,
  input  logic                 ps_lcntr_dec,
  output logic [PS_DATA_W-1:0] ps_rd_data,
  output logic                 ps_stk_full,
  output logic                 ps_stk_empty,
  output logic                 ps_lcntr_zero,
  output logic                 ps_stky_err
);

  localparam int IDX_W = (PS_STK_DEPTH > 1) ? $clog2(PS_STK_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  localparam logic [4:0] ADD_PCSTK  = 5'h04;
  localparam logic [4:0] ADD_PCSTKP = 5'h05;
  localparam logic [4:0] ADD_LCNTR  = 5'h06;
  localparam logic [4:0] ADD_MODE1  = 5'h07;
  localparam logic [4:0] ADD_STKY   = 5'h08;

  logic [PS_DATA_W-1:0] stk_mem [PS_STK_DEPTH];
  logic [CNT_W-1:0]     stk_cnt;
  logic [PS_DATA_W-1:0] lcntr;
  logic [PS_DATA_W-1:0] mode1;

  logic                 push_wr;
  logic                 do_pop;
  logic [IDX_W-1:0]     cnt_idx;
  logic [IDX_W-1:0]     top_idx;
  logic [PS_DATA_W-1:0] stk_top;
  logic [PS_DATA_W-1:0] stky_rd;

  // Loop counter decrement that sticks at zero instead of wrapping.
  function automatic logic [PS_DATA_W-1:0] sat_dec(input logic [PS_DATA_W-1:0] v);
    return (v == '0) ? '0 : v - PS_DATA_W'(1);
  endfunction

  // A write to PCSTK together with a pop is a top replace, not a push/pop pair.
  assign push_wr      = ps_wrt_en && (ps_wrt_add == ADD_PCSTK);
  assign do_pop       = ps_popstck && !push_wr;
  assign ps_stk_full  = (stk_cnt == CNT_W'(PS_STK_DEPTH));
  assign ps_stk_empty = (stk_cnt == '0);
  assign cnt_idx      = stk_cnt[IDX_W-1:0];
  assign top_idx      = IDX_W'(stk_cnt - CNT_W'(1));
  assign stk_top      = ps_stk_empty ? '0 : stk_mem[top_idx];
  assign ps_lcntr_zero = (lcntr == '0);

  // PC stack: replace top, push, or pop; over/underflow leaves the stack untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk_cnt <= '0;
      for (int i = 0; i < PS_STK_DEPTH; i++) stk_mem[i] <= '0;
    end else if (push_wr && ps_popstck && !ps_stk_empty) begin
      stk_mem[top_idx] <= ps_wrt_data;
    end else if (push_wr && !ps_stk_full) begin
      stk_mem[cnt_idx] <= ps_wrt_data;
      stk_cnt          <= stk_cnt + CNT_W'(1);
    end else if (do_pop && !ps_stk_empty) begin
      stk_cnt <= stk_cnt - CNT_W'(1);
    end
  end

  // LCNTR and MODE1; an explicit LCNTR write overrides a same-cycle decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcntr <= '0;
      mode1 <= '0;
    end else begin
      if (ps_wrt_en && (ps_wrt_add == ADD_LCNTR)) lcntr <= ps_wrt_data;
      else if (ps_lcntr_dec)                      lcntr <= sat_dec(lcntr);
      if (ps_wrt_en && (ps_wrt_add == ADD_MODE1)) mode1 <= ps_wrt_data;
    end
  end

`ifdef PS_UREG_STKY_EN
  logic stky_ovf;
  logic stky_unf;
  logic ovf_set;
  logic unf_set;
  logic stky_clr;

  assign ovf_set  = push_wr && !ps_popstck && ps_stk_full;
  assign unf_set  = do_pop && ps_stk_empty;
  assign stky_clr = ps_wrt_en && (ps_wrt_add == ADD_STKY);

  // Sticky error flags; a new error in the clearing cycle still gets recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stky_ovf <= 1'b0;
      stky_unf <= 1'b0;
    end else begin
      stky_ovf <= (stky_ovf && !stky_clr) || ovf_set;
      stky_unf <= (stky_unf && !stky_clr) || unf_set;
    end
  end

  assign stky_rd     = {{(PS_DATA_W-2){1'b0}}, stky_unf, stky_ovf};
  assign ps_stky_err = stky_ovf || stky_unf;
`else
  assign stky_rd     = '0;
  assign ps_stky_err = 1'b0;
`endif

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    ps_rd_data = '0;
    case (ps_rd_add)
      ADD_PCSTK:  ps_rd_data = stk_top;
      ADD_PCSTKP: ps_rd_data = PS_DATA_W'(stk_cnt);
      ADD_LCNTR:  ps_rd_data = lcntr;
      ADD_MODE1:  ps_rd_data = mode1;
      ADD_STKY:   ps_rd_data = stky_rd;
      default:    ps_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ps_ureg_file.sv
// tb_ps_ureg_file: directed bench for ps_ureg_file (16-bit, depth 8).
// Read expectations are queued when a read is issued and compared when the
// combinational read data has settled.
module tb_ps_ureg_file;

  localparam int W = 16;

`ifdef PS_UREG_STKY_EN
  localparam bit STKY_ON = 1'b1;
`else
  localparam bit STKY_ON = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         ps_wrt_en;
  logic [4:0]   ps_wrt_add;
  logic [W-1:0] ps_wrt_data;
  logic [4:0]   ps_rd_add;
  logic         ps_popstck;
  logic         ps_lcntr_dec;
  logic [W-1:0] ps_rd_data;
  logic         ps_stk_full;
  logic         ps_stk_empty;
  logic         ps_lcntr_zero;
  logic         ps_stky_err;

  typedef struct {
    string        tag;
    logic [4:0]   addr;
    logic [W-1:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_chk;
  int       n_err;

  ps_ureg_file #(.PS_DATA_W(W), .PS_STK_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps_wrt_en    (ps_wrt_en),
    .ps_wrt_add   (ps_wrt_add),
    .ps_wrt_data  (ps_wrt_data),
    .ps_rd_add    (ps_rd_add),
    .ps_popstck   (ps_popstck),
    .ps_lcntr_dec (ps_lcntr_dec),
    .ps_rd_data   (ps_rd_data),
    .ps_stk_full  (ps_stk_full),
    .ps_stk_empty (ps_stk_empty),
    .ps_lcntr_zero(ps_lcntr_zero),
    .ps_stky_err  (ps_stky_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Queue an expected read result, present the address, compare once settled.
  task automatic rd_exp(input string tag, input logic [4:0] addr, input logic [W-1:0] exp);
    sb_item_t it;
    sb_q.push_back('{tag: tag, addr: addr, exp: exp});
    ps_rd_add = addr;
    #1;
    it = sb_q.pop_front();
    chk(it.tag, 32'(ps_rd_data), 32'(it.exp));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [W-1:0] data);
    ps_wrt_en = 1'b1; ps_wrt_add = addr; ps_wrt_data = data;
    cyc();
    ps_wrt_en = 1'b0;
  endtask

  task automatic pop();
    ps_popstck = 1'b1;
    cyc();
    ps_popstck = 1'b0;
  endtask

  task automatic dec();
    ps_lcntr_dec = 1'b1;
    cyc();
    ps_lcntr_dec = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_empty"}, 32'(ps_stk_empty), 32'd1);
    chk({pfx, "_full"},  32'(ps_stk_full),  32'd0);
    chk({pfx, "_lcz"},   32'(ps_lcntr_zero), 32'd1);
    chk({pfx, "_err"},   32'(ps_stky_err),  32'd0);
    for (int a = 0; a < 32; a += 3) rd_exp({pfx, "_rd"}, 5'(a), '0);
    rd_exp({pfx, "_pcstk"},  5'h04, '0);
    rd_exp({pfx, "_pcstkp"}, 5'h05, '0);
    rd_exp({pfx, "_lcntr"},  5'h06, '0);
    rd_exp({pfx, "_mode1"},  5'h07, '0);
    rd_exp({pfx, "_stky"},   5'h08, '0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b0;
    ps_wrt_en = 1'b0; ps_wrt_add = '0; ps_wrt_data = '0;
    ps_rd_add = '0; ps_popstck = 1'b0; ps_lcntr_dec = 1'b0;

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);

    // Push two, pop one.
    wr(5'h04, 16'h1111);
    wr(5'h04, 16'h2222);
    rd_exp("p2_cnt", 5'h05, 16'd2);
    rd_exp("p2_top", 5'h04, 16'h2222);
    pop();
    rd_exp("p1_top", 5'h04, 16'h1111);
    rd_exp("p1_cnt", 5'h05, 16'd1);

    // No write-to-read bypass.
    ps_wrt_en = 1'b1; ps_wrt_add = 5'h06; ps_wrt_data = 16'h0007;
    rd_exp("nobyp_old", 5'h06, 16'h0000);
    cyc();
    ps_wrt_en = 1'b0;
    rd_exp("nobyp_new", 5'h06, 16'h0007);

    // Underflow.
    pop();
    chk("emp_flag", 32'(ps_stk_empty), 32'd1);
    pop();
    rd_exp("unf_cnt",  5'h05, 16'd0);
    rd_exp("unf_top",  5'h04, 16'd0);
    rd_exp("unf_stky", 5'h08, STKY_ON ? 16'h0002 : 16'h0000);
    chk("unf_err", 32'(ps_stky_err), 32'(STKY_ON));
    wr(5'h08, 16'h0000);
    rd_exp("unf_clr", 5'h08, 16'h0000);

    // Overflow: nine pushes into depth eight.
    for (int i = 1; i <= 9; i++) begin
      wr(5'h04, 16'(i * 16'h0101));
      if (i == 7) chk("full_7", 32'(ps_stk_full), 32'd0);
      if (i == 8) chk("full_8", 32'(ps_stk_full), 32'd1);
      if (i == 8) chk("err_8",  32'(ps_stky_err), 32'd0);
    end
    rd_exp("ovf_top",  5'h04, 16'h0808);
    rd_exp("ovf_cnt",  5'h05, 16'd8);
    rd_exp("ovf_stky", 5'h08, STKY_ON ? 16'h0001 : 16'h0000);
    chk("ovf_err", 32'(ps_stky_err), 32'(STKY_ON));
    wr(5'h08, 16'hFFFF);
    rd_exp("ovf_clr", 5'h08, 16'h0000);
    chk("ovf_err_clr", 32'(ps_stky_err), 32'd0);

    // Down to three entries, then replace the top.
    for (int i = 0; i < 5; i++) pop();
    rd_exp("r3_top", 5'h04, 16'h0303);
    ps_popstck = 1'b1;
    wr(5'h04, 16'hABCD);
    ps_popstck = 1'b0;
    rd_exp("rep_cnt", 5'h05, 16'd3);
    rd_exp("rep_top", 5'h04, 16'hABCD);
    pop();
    rd_exp("rep_below", 5'h04, 16'h0202);

    // Replace on an empty stack acts as a push.
    pop(); pop();
    chk("emp2", 32'(ps_stk_empty), 32'd1);
    ps_popstck = 1'b1;
    wr(5'h04, 16'h5555);
    ps_popstck = 1'b0;
    rd_exp("erep_cnt",  5'h05, 16'd1);
    rd_exp("erep_top",  5'h04, 16'h5555);
    rd_exp("erep_stky", 5'h08, 16'h0000);

    // Loop counter.
    wr(5'h06, 16'd2);
    chk("lc2_zero", 32'(ps_lcntr_zero), 32'd0);
    dec(); rd_exp("lc_dec1", 5'h06, 16'd1);
    dec(); rd_exp("lc_dec0", 5'h06, 16'd0);
    chk("lc0_zero", 32'(ps_lcntr_zero), 32'd1);
    dec(); rd_exp("lc_hold", 5'h06, 16'd0);
    chk("lch_zero", 32'(ps_lcntr_zero), 32'd1);
    ps_lcntr_dec = 1'b1;
    wr(5'h06, 16'd5);
    ps_lcntr_dec = 1'b0;
    rd_exp("lc_wrpri", 5'h06, 16'd5);

    // MODE1, read-only PCSTKP, unmapped addresses.
    wr(5'h07, 16'hBEEF);
    rd_exp("mode1", 5'h07, 16'hBEEF);
    wr(5'h05, 16'h0007);
    rd_exp("pcstkp_ro", 5'h05, 16'd1);
    wr(5'h03, 16'h1234);
    rd_exp("unmap3", 5'h03, 16'h0000);
    rd_exp("mode1_keep", 5'h07, 16'hBEEF);

    // Reset between pushes, including a push held during reset.
    wr(5'h04, 16'h7777);
    ps_wrt_en = 1'b1; ps_wrt_add = 5'h04; ps_wrt_data = 16'h6666;
    rst = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    cyc();
    chk("rst1_hold_empty", 32'(ps_stk_empty), 32'd1);
    ps_wrt_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wr(5'h04, 16'h8888);
    rd_exp("post_cnt", 5'h05, 16'd1);
    rd_exp("post_top", 5'h04, 16'h8888);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
